// File: rtl/iob_fe_arbiter.sv
// rtl/iob_fe_arbiter.sv - round-robin arbiter of two IOB requesters onto one cache front-end port
module iob_fe_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_valid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,

    output logic                busy_o,
    output logic                proto_err_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t state;
    logic   last_g;
    logic   lock;
    logic   lock_g;
    logic   rd_own;
    logic   proto_err;

    logic              g;
    logic              g_valid;
    logic              idle;
    logic              accept;
    logic [STRB_W-1:0] g_wstrb;

    assign idle = (state == IDLE);

    // A held lock outranks any new valids so a stalled request stays stable.
    always_comb begin
        g = 1'b0;
        if (lock) begin
            g = lock_g;
        end else if (m0_valid_i && m1_valid_i) begin
            g = ~last_g;
        end else if (m1_valid_i) begin
            g = 1'b1;
        end
    end

    assign g_valid = g ? m1_valid_i : m0_valid_i;
    assign g_wstrb = g ? m1_wstrb_i : m0_wstrb_i;

    assign s_valid_o = reset & idle & g_valid;
    assign s_addr_o  = g ? m1_addr_i  : m0_addr_i;
    assign s_wdata_o = g ? m1_wdata_i : m0_wdata_i;
    assign s_wstrb_o = g_wstrb;

    assign accept = s_valid_o & s_ready_i;

    assign m0_ready_o = accept & ~g;
    assign m1_ready_o = accept & g;

    // Read data is broadcast; only the owner's rvalid is raised.
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign m0_rvalid_o = reset & ~idle & s_rvalid_i & ~rd_own;
    assign m1_rvalid_o = reset & ~idle & s_rvalid_i & rd_own;

    assign busy_o      = reset & ~idle;
    assign proto_err_o = reset & proto_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_g    <= 1'b1;
            lock      <= 1'b0;
            lock_g    <= 1'b0;
            rd_own    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_rvalid_i) begin
                        proto_err <= 1'b1;
                    end
                    if (accept) begin
                        last_g <= g;
                        lock   <= 1'b0;
                        if (g_wstrb == '0) begin
                            rd_own <= g;
                            state  <= RD_WAIT;
                        end
                    end else if (s_valid_o) begin
                        lock   <= 1'b1;
                        lock_g <= g;
                    end
                end
                RD_WAIT: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_fe_arbiter.sv
// tb/tb_iob_fe_arbiter.sv - directed self-checking bench for iob_fe_arbiter
module tb_iob_fe_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              m0_valid_i = 1'b0;
    logic [ADDR_W-1:0] m0_addr_i = '0;
    logic [DATA_W-1:0] m0_wdata_i = '0;
    logic [STRB_W-1:0] m0_wstrb_i = '0;
    logic              m0_ready_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m1_valid_i = 1'b0;
    logic [ADDR_W-1:0] m1_addr_i = '0;
    logic [DATA_W-1:0] m1_wdata_i = '0;
    logic [STRB_W-1:0] m1_wstrb_i = '0;
    logic              m1_ready_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              s_valid_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic [STRB_W-1:0] s_wstrb_o;
    logic              s_ready_i = 1'b0;
    logic              s_rvalid_i = 1'b0;
    logic [DATA_W-1:0] s_rdata_i = '0;
    logic              busy_o;
    logic              proto_err_o;

    int checks = 0;
    int failures = 0;

    iob_fe_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o),
        .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            reset = 1'b0;
            m0_valid_i = 1'($urandom_range(0, 1));
            m1_valid_i = 1'($urandom_range(0, 1));
            m0_addr_i = ADDR_W'($urandom);
            m1_addr_i = ADDR_W'($urandom);
            m0_wstrb_i = STRB_W'($urandom);
            m1_wstrb_i = STRB_W'($urandom);
            s_ready_i = 1'($urandom_range(0, 1));
            s_rvalid_i = 1'($urandom_range(0, 1));
            s_rdata_i = $urandom;
            #1;
            checks++;
            if (s_valid_o !== 1'b0) begin
                failures++; $display("FAIL reset_s_valid cyc=%0d got=%b exp=0", i, s_valid_o);
            end
            checks++;
            if ({m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0) begin
                failures++;
                $display("FAIL reset_ready_rvalid cyc=%0d got=%b%b%b%b exp=0000", i,
                         m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o);
            end
            checks++;
            if ({busy_o, proto_err_o} !== 2'b00) begin
                failures++; $display("FAIL reset_busy_err cyc=%0d got=%b%b exp=00", i, busy_o, proto_err_o);
            end
            checks++;
            if (m0_rdata_o !== s_rdata_i || m1_rdata_o !== s_rdata_i) begin
                failures++;
                $display("FAIL reset_rdata_bcast got=%h/%h exp=%h", m0_rdata_o, m1_rdata_o, s_rdata_i);
            end
            @(negedge clk);
        end
        m0_valid_i = 0; m1_valid_i = 0; m0_wstrb_i = 0; m1_wstrb_i = 0;
        s_ready_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
        reset = 1'b1;
    endtask

    task automatic test_tie();
        m0_valid_i = 1; m0_addr_i = 30'h10; m0_wstrb_i = 0;
        m1_valid_i = 1; m1_addr_i = 30'h20; m1_wstrb_i = 0;
        s_ready_i = 1;
        #1;
        checks++;
        if (s_valid_o !== 1'b1 || s_addr_o !== 30'h10 || m0_ready_o !== 1'b1 || m1_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL tie_first_grant got v=%b a=%h r0=%b r1=%b exp v=1 a=10 r0=1 r1=0",
                     s_valid_o, s_addr_o, m0_ready_o, m1_ready_o);
        end
        @(negedge clk);
        m0_valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (busy_o !== 1'b1 || s_valid_o !== 1'b0 || m1_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL tie_rd_wait cyc=%0d got busy=%b v=%b r1=%b exp busy=1 v=0 r1=0",
                         i, busy_o, s_valid_o, m1_ready_o);
            end
            @(negedge clk);
        end
        s_rvalid_i = 1; s_rdata_i = 32'hA5A5A5A5;
        #1;
        checks++;
        if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL tie_m0_resp got rv0=%b rv1=%b d=%h exp rv0=1 rv1=0 d=a5a5a5a5",
                     m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
        end
        @(negedge clk);
        s_rvalid_i = 0;
        #1;
        checks++;
        if (s_valid_o !== 1'b1 || s_addr_o !== 30'h20 || m1_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL tie_m1_grant got v=%b a=%h r1=%b busy=%b exp v=1 a=20 r1=1 busy=0",
                     s_valid_o, s_addr_o, m1_ready_o, busy_o);
        end
        @(negedge clk);
        m1_valid_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h12345678;
        #1;
        checks++;
        if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL tie_m1_resp got rv0=%b rv1=%b exp rv0=0 rv1=1", m0_rvalid_o, m1_rvalid_o);
        end
        @(negedge clk);
        s_rvalid_i = 0;
    endtask

    task automatic test_lock();
        m1_valid_i = 1; m1_addr_i = 30'h7; m1_wdata_i = 32'h55; m1_wstrb_i = 4'hF;
        s_ready_i = 0;
        #1;
        checks++;
        if (s_addr_o !== 30'h7 || s_valid_o !== 1'b1 || m1_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_stall0 got a=%h v=%b r1=%b exp a=7 v=1 r1=0", s_addr_o, s_valid_o, m1_ready_o);
        end
        @(negedge clk);
        m0_valid_i = 1; m0_addr_i = 30'h3; m0_wdata_i = 32'h66; m0_wstrb_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_addr_o !== 30'h7 || s_wstrb_o !== 4'hF || s_wdata_o !== 32'h55 ||
                m0_ready_o !== 1'b0 || m1_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold cyc=%0d got a=%h s=%h d=%h r0=%b r1=%b exp a=7 s=f d=55 r0=0 r1=0",
                         i, s_addr_o, s_wstrb_o, s_wdata_o, m0_ready_o, m1_ready_o);
            end
            @(negedge clk);
        end
        s_ready_i = 1;
        #1;
        checks++;
        if (m1_ready_o !== 1'b1 || m0_ready_o !== 1'b0 || s_addr_o !== 30'h7) begin
            failures++;
            $display("FAIL lock_release got r1=%b r0=%b a=%h exp r1=1 r0=0 a=7", m1_ready_o, m0_ready_o, s_addr_o);
        end
        @(negedge clk);
        m1_valid_i = 0;
        #1;
        checks++;
        if (s_addr_o !== 30'h3 || m0_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_next_m0 got a=%h r0=%b busy=%b exp a=3 r0=1 busy=0", s_addr_o, m0_ready_o, busy_o);
        end
        @(negedge clk);
        m0_valid_i = 0;
    endtask

    task automatic test_fairness();
        m1_valid_i = 1; m1_addr_i = 30'h200; m1_wstrb_i = 4'hF; s_ready_i = 1;
        #1;
        checks++;
        if (m1_ready_o !== 1'b1) begin
            failures++; $display("FAIL fair_prelude got r1=%b exp=1", m1_ready_o);
        end
        @(negedge clk);
        m0_valid_i = 1; m0_addr_i = 30'h100; m0_wstrb_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            logic              exp_g;
            logic [ADDR_W-1:0] exp_a;
            exp_g = 1'(i % 2);
            exp_a = exp_g ? 30'h200 : 30'h100;
            #1;
            checks++;
            if (s_addr_o !== exp_a || m0_ready_o !== ~exp_g || m1_ready_o !== exp_g) begin
                failures++;
                $display("FAIL fair_alt cyc=%0d got a=%h r0=%b r1=%b exp a=%h r0=%b r1=%b",
                         i, s_addr_o, m0_ready_o, m1_ready_o, exp_a, ~exp_g, exp_g);
            end
            @(negedge clk);
        end
        m0_valid_i = 0; m1_valid_i = 0;
    endtask

    task automatic test_routing();
        m1_valid_i = 1; m1_addr_i = 30'h30; m1_wstrb_i = 0; s_ready_i = 1;
        #1;
        checks++;
        if (m1_ready_o !== 1'b1) begin
            failures++; $display("FAIL route_accept got r1=%b exp=1", m1_ready_o);
        end
        @(negedge clk);
        m1_valid_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0 ||
            m1_rdata_o !== 32'hDEADBEEF || m0_rdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL route_resp got rv1=%b rv0=%b d1=%h d0=%h exp rv1=1 rv0=0 d=deadbeef",
                     m1_rvalid_o, m0_rvalid_o, m1_rdata_o, m0_rdata_o);
        end
        @(negedge clk);
        s_rvalid_i = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || proto_err_o !== 1'b0) begin
            failures++; $display("FAIL route_after got busy=%b err=%b exp 0 0", busy_o, proto_err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_error_reset();
        s_rvalid_i = 1;
        #1;
        checks++;
        if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
            failures++; $display("FAIL err_no_rvalid got rv0=%b rv1=%b exp 0 0", m0_rvalid_o, m1_rvalid_o);
        end
        @(negedge clk);
        s_rvalid_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (proto_err_o !== 1'b1) begin
                failures++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", i, proto_err_o);
            end
            @(negedge clk);
        end
        m0_valid_i = 1; m0_addr_i = 30'h40; m0_wstrb_i = 0; s_ready_i = 1;
        @(negedge clk);
        m0_valid_i = 0;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++; $display("FAIL err_rd_wait got busy=%b exp=1", busy_o);
        end
        reset = 0;
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || proto_err_o !== 1'b0 || s_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL err_after_reset got busy=%b err=%b v=%b exp 0 0 0", busy_o, proto_err_o, s_valid_o);
        end
        m1_valid_i = 1; m1_addr_i = 30'h50; m1_wstrb_i = 4'hF;
        #1;
        checks++;
        if (s_valid_o !== 1'b1 || m1_ready_o !== 1'b1 || s_addr_o !== 30'h50) begin
            failures++;
            $display("FAIL err_idle_again got v=%b r1=%b a=%h exp v=1 r1=1 a=50", s_valid_o, m1_ready_o, s_addr_o);
        end
        @(negedge clk);
        m1_valid_i = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tie();
        test_lock();
        test_fairness();
        test_routing();
        test_error_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
